// File: rtl/pc_sequencer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pc_seq_pkg                                                      |
// | Brief    : Shared types for the PC next-address sequencer.                 |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
package pc_seq_pkg;

  localparam int PC_W = 15;

  typedef logic [PC_W-1:0] pc_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_HALT  = 2'd2,
    ST_FAULT = 2'd3
  } state_t;

  // Modulo-2^15 increment; 15'h7FFF wraps to 15'h0000.
  function automatic pc_t pc_inc(input pc_t a);
    return a + pc_t'(1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pc_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pc_sequencer_if                                                 |
// | Brief    : Decode-side request bus and PC-register drive for pc_sequencer. |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
interface pc_sequencer_if #(
  parameter int STACK_DEPTH = 8
);
  import pc_seq_pkg::*;

  localparam int LVL_W = $clog2(STACK_DEPTH) + 1;

  logic             start;
  logic             halt;
  logic             stall;
  pc_t              pc_in;
  logic             branch_taken;
  logic             jump;
  logic             call;
  logic             ret;
  pc_t              target;
  logic             pc_load;
  pc_t              pc_next;
  logic             running;
  logic             fault;
  logic [LVL_W-1:0] stack_level;

  modport master (
    output start, halt, stall, pc_in, branch_taken, jump, call, ret, target,
    input  pc_load, pc_next, running, fault, stack_level
  );

  modport slave (
    input  start, halt, stall, pc_in, branch_taken, jump, call, ret, target,
    output pc_load, pc_next, running, fault, stack_level
  );

endinterface
`default_nettype wire

// File: rtl/pc_sequencer_return_stack.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : return_stack                                                    |
// | Brief    : LIFO of return addresses with full/empty/level status.          |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module return_stack #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 15
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [WIDTH-1:0]         i_data,
  output logic [WIDTH-1:0]         o_top,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [LW-1:0]    r_ptr;
  logic [AW-1:0]    w_wr_idx;
  logic [AW-1:0]    w_rd_idx;

  // r_ptr counts entries; its low bits address the next free slot.
  assign w_wr_idx = r_ptr[AW-1:0];
  assign w_rd_idx = w_wr_idx - AW'(1);
  assign o_full   = (r_ptr == LW'(DEPTH));
  assign o_empty  = (r_ptr == '0);
  assign o_level  = r_ptr;
  assign o_top    = r_mem[w_rd_idx];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ptr <= '0;
    end else if (i_push && !o_full) begin
      r_ptr <= r_ptr + LW'(1);
    end else if (i_pop && !o_empty) begin
      r_ptr <= r_ptr - LW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (i_push && !o_full) begin
      r_mem[w_wr_idx] <= i_data;
    end
  end

endmodule
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pc_sequencer                                                    |
// | Brief    : Next-address controller driving PC register enable/step.        |
// |            Return stack enabled by defining PC_SEQ_CALL_STACK_EN.          |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter pc_t RESET_VECTOR = 15'd0,
  parameter int  STACK_DEPTH  = 8
) (
  input  logic          clk,
  input  logic          reset,
  pc_sequencer_if.slave bus
);

  localparam int LVL_W = $clog2(STACK_DEPTH) + 1;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_running;
  logic             r_fault;
  logic             w_load;
  pc_t              w_next;
  logic [LVL_W-1:0] w_level;

`ifdef PC_SEQ_CALL_STACK_EN
  logic w_push;
  logic w_pop;
  logic w_full;
  logic w_empty;
  pc_t  w_top;
  pc_t  w_ret_addr;

  assign w_ret_addr = pc_inc(bus.pc_in);

  return_stack #(
    .DEPTH (STACK_DEPTH),
    .WIDTH (PC_W)
  ) u_stack (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_ret_addr),
    .o_top   (w_top),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (w_level)
  );
`else
  logic w_unused_ret;

  assign w_unused_ret = bus.ret;
  assign w_level      = '0;
`endif

  always_comb begin
    w_load      = 1'b0;
    w_next      = bus.pc_in;
    w_state_nxt = r_state;
`ifdef PC_SEQ_CALL_STACK_EN
    w_push      = 1'b0;
    w_pop       = 1'b0;
`endif
    case (r_state)
      ST_IDLE: begin
        w_next = RESET_VECTOR;
        if (bus.start) begin
          w_load      = 1'b1;
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (bus.halt) begin
          w_state_nxt = ST_HALT;
        end else if (bus.stall) begin
          w_load = 1'b0;
`ifdef PC_SEQ_CALL_STACK_EN
        end else if (bus.ret) begin
          if (w_empty) begin
            w_state_nxt = ST_FAULT;
          end else begin
            w_load = 1'b1;
            w_next = w_top;
            w_pop  = 1'b1;
          end
        end else if (bus.call) begin
          if (w_full) begin
            w_state_nxt = ST_FAULT;
          end else begin
            w_load = 1'b1;
            w_next = bus.target;
            w_push = 1'b1;
          end
`else
        end else if (bus.call) begin
          w_load = 1'b1;
          w_next = bus.target;
`endif
        end else if (bus.jump || bus.branch_taken) begin
          w_load = 1'b1;
          w_next = bus.target;
        end else begin
          w_load = 1'b1;
          w_next = pc_inc(bus.pc_in);
        end
      end
      // Resuming from HALT takes no load; the PC register already holds the resume address.
      ST_HALT: begin
        if (bus.start) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_FAULT: begin
        w_state_nxt = ST_FAULT;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_running <= 1'b0;
      r_fault   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_running <= (w_state_nxt == ST_RUN);
      r_fault   <= (w_state_nxt == ST_FAULT);
    end
  end

  assign bus.pc_load     = w_load;
  assign bus.pc_next     = w_next;
  assign bus.running     = r_running;
  assign bus.fault       = r_fault;
  assign bus.stack_level = w_level;

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_pc_sequencer                                                 |
// | Brief    : Self-checking bench for pc_sequencer against a queue-based model.|
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_pc_sequencer;
  import pc_seq_pkg::*;

  localparam pc_t RV    = 15'h0010;
  localparam int  DEPTH = 8;
`ifdef PC_SEQ_CALL_STACK_EN
  localparam bit  STK   = 1'b1;
`else
  localparam bit  STK   = 1'b0;
`endif
  localparam int M_IDLE = 0, M_RUN = 1, M_HALT = 2, M_FAULT = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pc_sequencer_if #(.STACK_DEPTH(DEPTH)) bus ();

  pc_sequencer #(
    .RESET_VECTOR (RV),
    .STACK_DEPTH  (DEPTH)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int   total = 0;
  int   bad   = 0;
  int   m_state;
  int   m_state_n;
  int   m_op;
  pc_t  m_stk[$];
  bit   m_load;
  pc_t  m_next;
  pc_t  m_push_val;
  pc_t  m_dummy;

  function automatic pc_t plus1(input pc_t a);
    return pc_t'((int'(a) + 1) % 32768);
  endfunction

  function automatic logic [5:0] exp_status();
    return {m_state == M_RUN, m_state == M_FAULT, 4'(m_stk.size())};
  endfunction

  task automatic model_reset();
    m_state = M_IDLE;
    m_stk.delete();
  endtask

  task automatic model_eval();
    m_load    = 1'b0;
    m_next    = bus.pc_in;
    m_state_n = m_state;
    m_op      = 0;
    case (m_state)
      M_IDLE: begin
        m_next = RV;
        if (bus.start) begin m_load = 1'b1; m_state_n = M_RUN; end
      end
      M_RUN: begin
        if (bus.halt) m_state_n = M_HALT;
        else if (bus.stall) m_op = 0;
        else if (STK && bus.ret) begin
          if (m_stk.size() == 0) m_state_n = M_FAULT;
          else begin m_load = 1'b1; m_next = m_stk[$]; m_op = 2; end
        end else if (bus.call) begin
          if (STK && m_stk.size() == DEPTH) m_state_n = M_FAULT;
          else begin
            m_load = 1'b1; m_next = bus.target;
            m_op = STK ? 1 : 0; m_push_val = plus1(bus.pc_in);
          end
        end else if (bus.jump || bus.branch_taken) begin
          m_load = 1'b1; m_next = bus.target;
        end else begin
          m_load = 1'b1; m_next = plus1(bus.pc_in);
        end
      end
      M_HALT: if (bus.start) m_state_n = M_RUN;
      default: m_state_n = m_state;
    endcase
  endtask

  task automatic idle_inputs();
    bus.start = 0; bus.halt = 0; bus.stall = 0; bus.branch_taken = 0;
    bus.jump = 0; bus.call = 0; bus.ret = 0; bus.target = '0;
  endtask

  task automatic settle();
    #1;
    model_eval();
  endtask

  // Clock edge acts as the PC register: load pc_next when pc_load was modelled high.
  task automatic tick();
    @(posedge clk);
    #1;
    m_state = m_state_n;
    if (m_op == 1) m_stk.push_back(m_push_val);
    else if (m_op == 2) m_dummy = m_stk.pop_back();
    if (m_load) bus.pc_in = m_next;
  endtask

  task automatic do_reset_start();
    idle_inputs();
    reset = 1'b0;
    #2;
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b1;
    settle();
    tick();
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    bus.pc_in = RV;
    reset = 1'b0;
    model_reset();
    #3;
    total++;
    if (bus.pc_load !== 1'b0 || bus.pc_next !== RV) begin
      bad++; $display("FAIL reset_outputs: load/next got %0b/%h want 0/%h", bus.pc_load, bus.pc_next, RV);
    end
    total++;
    if ({bus.running, bus.fault, bus.stack_level} !== 6'd0) begin
      bad++; $display("FAIL reset_status: got %b want 000000", {bus.running, bus.fault, bus.stack_level});
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_start_seq();
    pc_t want[4] = '{15'h0010, 15'h0011, 15'h0012, 15'h0013};
    bus.start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      settle();
      total++;
      if (bus.pc_load !== 1'b1 || bus.pc_next !== want[i]) begin
        bad++; $display("FAIL start_seq[%0d]: load/next got %0b/%h want 1/%h", i, bus.pc_load, bus.pc_next, want[i]);
      end
      tick();
      bus.start = 1'b0;
    end
    total++;
    if (bus.running !== 1'b1) begin
      bad++; $display("FAIL start_running: got %0b want 1", bus.running);
    end
  endtask

  task automatic test_wrap();
    idle_inputs();
    bus.pc_in = 15'h7FFF;
    settle();
    total++;
    if (bus.pc_load !== 1'b1 || bus.pc_next !== 15'h0000) begin
      bad++; $display("FAIL wrap: load/next got %0b/%h want 1/0000", bus.pc_load, bus.pc_next);
    end
    tick();
    total++;
    if (bus.fault !== 1'b0) begin
      bad++; $display("FAIL wrap_fault: got %0b want 0", bus.fault);
    end
  endtask

  task automatic test_call_ret();
    idle_inputs();
    bus.pc_in = 15'h0040;
    for (int i = 0; i < 4; i++) begin
      bus.call   = (i == 0);
      bus.target = 15'h0200;
      bus.ret    = (i == 3);
      settle();
      total++;
      if (bus.pc_load !== m_load || bus.pc_next !== m_next) begin
        bad++; $display("FAIL call_ret[%0d]: load/next got %0b/%h want %0b/%h", i, bus.pc_load, bus.pc_next, m_load, m_next);
      end
      tick();
      total++;
      if ({bus.running, bus.fault, bus.stack_level} !== exp_status()) begin
        bad++; $display("FAIL call_ret_status[%0d]: got %b want %b", i, {bus.running, bus.fault, bus.stack_level}, exp_status());
      end
    end
    idle_inputs();
  endtask

  task automatic test_stall_jump();
    pc_t held;
    idle_inputs();
    held = bus.pc_in;
    bus.stall = 1'b1; bus.jump = 1'b1; bus.target = 15'h1234;
    settle();
    total++;
    if (bus.pc_load !== 1'b0 || bus.pc_next !== held) begin
      bad++; $display("FAIL stall_jump: load/next got %0b/%h want 0/%h", bus.pc_load, bus.pc_next, held);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_halt_resume();
    pc_t held;
    idle_inputs();
    bus.pc_in = 15'h0333;
    held = bus.pc_in;
    for (int i = 0; i < 4; i++) begin
      bus.halt  = (i == 0);
      bus.start = (i == 2);
      settle();
      total++;
      if (bus.pc_load !== m_load || bus.pc_next !== m_next) begin
        bad++; $display("FAIL halt_resume[%0d]: load/next got %0b/%h want %0b/%h", i, bus.pc_load, bus.pc_next, m_load, m_next);
      end
      tick();
      total++;
      if ({bus.running, bus.fault, bus.stack_level} !== exp_status()) begin
        bad++; $display("FAIL halt_status[%0d]: got %b want %b", i, {bus.running, bus.fault, bus.stack_level}, exp_status());
      end
    end
    total++;
    if (bus.pc_in !== plus1(held)) begin
      bad++; $display("FAIL halt_seq: pc got %h want %h", bus.pc_in, plus1(held));
    end
    idle_inputs();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      bus.halt         = ($urandom_range(0, 24) == 0);
      bus.start        = ($urandom_range(0, 2) == 0);
      bus.stall        = ($urandom_range(0, 4) == 0);
      bus.ret          = ($urandom_range(0, 3) == 0) && (m_stk.size() > 0);
      bus.call         = ($urandom_range(0, 3) == 0) && (m_stk.size() < DEPTH);
      bus.jump         = ($urandom_range(0, 5) == 0);
      bus.branch_taken = ($urandom_range(0, 5) == 0);
      bus.target       = pc_t'($urandom);
      if ($urandom_range(0, 7) == 0) bus.pc_in = pc_t'($urandom);
      settle();
      total++;
      if (bus.pc_load !== m_load || bus.pc_next !== m_next) begin
        bad++; $display("FAIL random[%0d]: load/next got %0b/%h want %0b/%h", i, bus.pc_load, bus.pc_next, m_load, m_next);
      end
      tick();
      total++;
      if ({bus.running, bus.fault, bus.stack_level} !== exp_status()) begin
        bad++; $display("FAIL random_status[%0d]: got %b want %b", i, {bus.running, bus.fault, bus.stack_level}, exp_status());
      end
    end
    idle_inputs();
  endtask

  task automatic test_reset_midrun();
    do_reset_start();
    for (int i = 0; i < 3; i++) begin
      bus.call = 1'b1; bus.target = pc_t'($urandom);
      settle();
      tick();
    end
    idle_inputs();
    total++;
    if ({bus.running, bus.fault, bus.stack_level} !== exp_status()) begin
      bad++; $display("FAIL midrun_pre: got %b want %b", {bus.running, bus.fault, bus.stack_level}, exp_status());
    end
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    total++;
    if ({bus.pc_load, bus.running, bus.fault, bus.stack_level} !== 7'd0) begin
      bad++; $display("FAIL midrun_reset: got %b want 0000000", {bus.pc_load, bus.running, bus.fault, bus.stack_level});
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_fault();
    do_reset_start();
    for (int i = 0; i < 11; i++) begin
      bus.call   = (i < 9);
      bus.start  = (i == 10);
      bus.target = pc_t'($urandom);
      settle();
      total++;
      if (bus.pc_load !== m_load || bus.pc_next !== m_next) begin
        bad++; $display("FAIL overflow[%0d]: load/next got %0b/%h want %0b/%h", i, bus.pc_load, bus.pc_next, m_load, m_next);
      end
      tick();
      total++;
      if ({bus.running, bus.fault, bus.stack_level} !== exp_status()) begin
        bad++; $display("FAIL overflow_status[%0d]: got %b want %b", i, {bus.running, bus.fault, bus.stack_level}, exp_status());
      end
    end
    do_reset_start();
    for (int i = 0; i < 2; i++) begin
      bus.ret   = (i == 0);
      bus.start = (i == 1);
      settle();
      total++;
      if (bus.pc_load !== m_load || bus.pc_next !== m_next) begin
        bad++; $display("FAIL underflow[%0d]: load/next got %0b/%h want %0b/%h", i, bus.pc_load, bus.pc_next, m_load, m_next);
      end
      tick();
      total++;
      if ({bus.running, bus.fault, bus.stack_level} !== exp_status()) begin
        bad++; $display("FAIL underflow_status[%0d]: got %b want %b", i, {bus.running, bus.fault, bus.stack_level}, exp_status());
      end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_start_seq();
    test_wrap();
    test_call_ret();
    test_stall_jump();
    test_halt_resume();
    test_random();
    test_reset_midrun();
    test_fault();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
